uart_rx_oversample: RTL

- 16x-oversampling UART receive front end.
- Sits directly upstream of the AHB UART's receive FIFO: converts the raw `rx` pin into byte-wide data with one-cycle `done`/`err` strobes.
- Replaces the single-sample receiver with a synchronised, majority-voted, false-start-rejecting receiver.
- Driven by an external oversample tick from the baud rate generator.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_oversample.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Centre tick of a bit period; the vote window is mid-1 .. mid+1.
  function automatic int mid_idx(input int oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// configurable reset value so the output idles at the line's rest level.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: synchronised, 3-sample majority vote, false-start
// and break rejection. Define UART_RX_PARITY_EN to add a parity bit and port.
module uart_rx_oversample
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int CNT_BITS   = $clog2(OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       in,
`ifdef UART_RX_PARITY_EN
  input  logic       parity_odd,
`endif
  output logic [7:0] data,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int                  M        = mid_idx(OVERSAMPLE);
  localparam logic [CNT_BITS-1:0] T_LO     = CNT_BITS'(M - 1);
  localparam logic [CNT_BITS-1:0] T_MID    = CNT_BITS'(M);
  localparam logic [CNT_BITS-1:0] T_HI     = CNT_BITS'(M + 1);
  localparam logic [CNT_BITS-1:0] T_END    = CNT_BITS'(OVERSAMPLE - 1);
  localparam logic [2:0]          LAST_BIT = 3'(DATA_BITS - 1);

  logic                s;
  rx_state_t           state_q;
  logic [CNT_BITS-1:0] tcnt_q;
  logic [CNT_BITS-1:0] tcnt_d;
  logic [2:0]          bit_idx_q;
  logic [1:0]          samp_q;
  logic [7:0]          shreg_q;
  logic [7:0]          data_q;
  logic                done_q;
  logic                err_q;
  logic                armed_q;
  logic                vote;
  logic                par_bad;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (in),
    .q_o   (s)
  );

  assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & s) | (samp_q[1] & s);
  assign tcnt_d = (tcnt_q == T_END) ? '0 : tcnt_q + 1'b1;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bit_idx_q <= '0;
      samp_q    <= '1;
      shreg_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      armed_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (en) begin
        if (state_q == IDLE) begin
          tcnt_q <= '0;
          // After an error the line must be seen high before a new start is taken.
          if (s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= START;
            shreg_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end
        end else begin
          tcnt_q <= tcnt_d;
          if (tcnt_q == T_LO)  samp_q[0] <= s;
          if (tcnt_q == T_MID) samp_q[1] <= s;
          case (state_q)
            START: begin
              if (tcnt_q == T_HI && vote) begin
                state_q <= IDLE;
                tcnt_q  <= '0;
              end else if (tcnt_q == T_END) begin
                state_q   <= DATA;
                bit_idx_q <= '0;
              end
            end
            DATA: begin
              if (tcnt_q == T_HI) shreg_q[bit_idx_q] <= vote;
              if (tcnt_q == T_END) begin
                if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_q <= PARITY;
`else
                  state_q <= STOP;
`endif
                end else begin
                  bit_idx_q <= bit_idx_q + 3'd1;
                end
              end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
              if (tcnt_q == T_HI) par_bad_q <= (^shreg_q) ^ vote ^ parity_odd;
              if (tcnt_q == T_END) state_q <= STOP;
            end
`endif
            STOP: begin
              // Leave at mid stop bit so the next start edge is never missed.
              if (tcnt_q == T_HI) begin
                state_q <= IDLE;
                tcnt_q  <= '0;
                if (vote && !par_bad) begin
                  data_q <= shreg_q;
                  done_q <= 1'b1;
                end else begin
                  err_q   <= 1'b1;
                  armed_q <= 1'b0;
                end
              end
            end
            default: begin
              state_q <= IDLE;
              tcnt_q  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign data = data_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);

endmodule
